// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment table,
// blank pattern and scan FSM encoding.
package seg7_pkg;

    // All cathodes off (active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex glyphs, {CG..CA}, active-low. Entry i is the glyph for nibble i.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an active-low multi-digit seven-segment
// display. Each digit gets a SHOW slot followed by an all-off BLANK slot;
// new data from the load handshake is only adopted at the frame boundary
// (the BLANK->SHOW step onto digit 0), so a frame never mixes two values.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int PRESCALE  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    input  logic                  load,
    output logic                  load_ack,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            SEG,
    output logic                  DP
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    scan_state_t          state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [IDX_W-1:0]     idx, idx_nx;
    logic                 boundary, xfer;

    logic [4*DIGITS-1:0]  disp_data, pend_data, disp_data_nx;
    logic [DIGITS-1:0]    disp_dp, pend_dp, disp_dp_nx;
    logic [DIGITS-1:0]    disp_en, pend_en, disp_en_nx;
    logic                 pend_v;

    logic [DIGITS-1:0][3:0] nib_nx;
    logic [6:0]           seg_dec;
    logic [DIGITS-1:0]    an_d;
    logic [6:0]           seg_d;
    logic                 dp_d;

    // Scan FSM next state: slot counter, digit index and frame boundary.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        boundary = 1'b0;
        case (state)
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nx = ST_BLANK;
                    cnt_nx   = '0;
                end
            end
            default: begin
                if (cnt == BLANK_LAST) begin
                    state_nx = ST_SHOW;
                    cnt_nx   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nx   = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
        endcase
    end

    // The display register as it will be after this edge, so the first
    // SHOW of a frame already uses freshly transferred data.
    assign xfer         = boundary & pend_v;
    assign disp_data_nx = xfer ? pend_data : disp_data;
    assign disp_dp_nx   = xfer ? pend_dp   : disp_dp;
    assign disp_en_nx   = xfer ? pend_en   : disp_en;
    assign nib_nx       = disp_data_nx;

    seg7_hex_decode u_dec (
        .nibble (nib_nx[idx_nx]),
        .seg    (seg_dec)
    );

    // Output values for the next state. A masked digit keeps its slot and
    // its cathode pattern; only the anode is withheld, so brightness of the
    // remaining digits is unchanged.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_nx == ST_SHOW) begin
            seg_d = seg_dec;
            dp_d  = ~disp_dp_nx[idx_nx];
            if (disp_en_nx[idx_nx])
                an_d[idx_nx] = 1'b0;
        end
    end

    // FSM state and registered display outputs, updated on the same edge.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= IDX_LAST;
            AN         <= '1;
            SEG        <= SEG_OFF;
            DP         <= 1'b1;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            AN         <= an_d;
            SEG        <= seg_d;
            DP         <= dp_d;
            frame_done <= boundary;
            load_ack   <= xfer;
        end
    end

    // Pending/display registers. A load on the boundary edge lands in
    // pending after the old contents have moved to the display, and keeps
    // pend_v set so it is shown from the following frame.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            disp_data <= '0;
            disp_dp   <= '0;
            disp_en   <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            pend_v    <= 1'b0;
        end else begin
            disp_data <= disp_data_nx;
            disp_dp   <= disp_dp_nx;
            disp_en   <= disp_en_nx;
            if (xfer)
                pend_v <= 1'b0;
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
                pend_en   <= en_in;
                pend_v    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, PRESCALE=8,
// BLANK_CYC=2 (40-cycle frame). Each task ends 1 ns after a boundary edge.
module tb_seg7_scan_driver;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en_in = '0;
    logic        load = 1'b0;
    logic        load_ack, frame_done;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    int checks = 0;
    int passes = 0;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(8), .BLANK_CYC(2)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .load       (load),
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        data_in = d; dp_in = dp; en_in = en; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic test_reset;
        RSTN = 1'b0;
        step(2);
        checks++; if (AN !== 4'hF) $display("FAIL rst_an got %b exp 1111", AN); else passes++;
        checks++; if (SEG !== 7'h7F) $display("FAIL rst_seg got %h exp 7f", SEG); else passes++;
        checks++; if (DP !== 1'b1) $display("FAIL rst_dp got %b exp 1", DP); else passes++;
        checks++; if (load_ack !== 1'b0) $display("FAIL rst_ack got %b exp 0", load_ack); else passes++;
        checks++; if (frame_done !== 1'b0) $display("FAIL rst_fd got %b exp 0", frame_done); else passes++;
        RSTN = 1'b1;
        step(1);
        checks++; if (AN !== 4'hF || frame_done !== 1'b0) $display("FAIL rst_blank1 got an=%b fd=%b exp 1111/0", AN, frame_done); else passes++;
        step(1);
        checks++; if (frame_done !== 1'b1) $display("FAIL rst_first_fd got %b exp 1", frame_done); else passes++;
        checks++; if (load_ack !== 1'b0) $display("FAIL rst_first_ack got %b exp 0", load_ack); else passes++;
        // display is all-zero with en=0: digit 0 glyph present, anode off
        checks++; if (AN !== 4'hF || SEG !== 7'h40) $display("FAIL rst_first_show got an=%b seg=%h exp 1111/40", AN, SEG); else passes++;
    endtask

    task automatic test_basic;
        do_load(16'h3A10, 4'b0010, 4'hF);
        step(38);
        checks++; if (frame_done !== 1'b0 || load_ack !== 1'b0) $display("FAIL basic_preb got fd=%b ack=%b exp 0/0", frame_done, load_ack); else passes++;
        step(1);
        checks++; if (frame_done !== 1'b1 || load_ack !== 1'b1) $display("FAIL basic_ack got fd=%b ack=%b exp 1/1", frame_done, load_ack); else passes++;
        checks++; if (AN !== 4'b1110 || SEG !== 7'h40 || DP !== 1'b1) $display("FAIL basic_d0 got %b/%h/%b exp 1110/40/1", AN, SEG, DP); else passes++;
        step(7);
        checks++; if (AN !== 4'b1110 || load_ack !== 1'b0 || frame_done !== 1'b0) $display("FAIL basic_d0_end got an=%b ack=%b fd=%b exp 1110/0/0", AN, load_ack, frame_done); else passes++;
        step(1);
        checks++; if (AN !== 4'hF || SEG !== 7'h7F || DP !== 1'b1) $display("FAIL basic_blank got %b/%h/%b exp 1111/7f/1", AN, SEG, DP); else passes++;
        step(1);
        checks++; if (AN !== 4'hF) $display("FAIL basic_blank2 got %b exp 1111", AN); else passes++;
        step(1);
        checks++; if (AN !== 4'b1101 || SEG !== 7'h79 || DP !== 1'b0) $display("FAIL basic_d1 got %b/%h/%b exp 1101/79/0", AN, SEG, DP); else passes++;
        step(10);
        checks++; if (AN !== 4'b1011 || SEG !== 7'h08 || DP !== 1'b1) $display("FAIL basic_d2 got %b/%h/%b exp 1011/08/1", AN, SEG, DP); else passes++;
        step(10);
        checks++; if (AN !== 4'b0111 || SEG !== 7'h30) $display("FAIL basic_d3 got %b/%h exp 0111/30", AN, SEG); else passes++;
        step(10);
        checks++; if (frame_done !== 1'b1 || load_ack !== 1'b0) $display("FAIL basic_b2 got fd=%b ack=%b exp 1/0", frame_done, load_ack); else passes++;
    endtask

    task automatic test_back_to_back;
        do_load(16'h1111, 4'h0, 4'hF);
        do_load(16'h2222, 4'h0, 4'hF);
        step(38);
        checks++; if (load_ack !== 1'b1 || SEG !== 7'h24 || AN !== 4'b1110) $display("FAIL b2b_ack got ack=%b seg=%h an=%b exp 1/24/1110", load_ack, SEG, AN); else passes++;
        step(1);
        checks++; if (load_ack !== 1'b0) $display("FAIL b2b_single got %b exp 0", load_ack); else passes++;
        for (int d = 1; d < 4; d++) begin
            step(d == 1 ? 9 : 10);
            checks++; if (SEG !== 7'h24) $display("FAIL b2b_d%0d got %h exp 24", d, SEG); else passes++;
        end
        step(10);
        checks++; if (frame_done !== 1'b1 || load_ack !== 1'b0) $display("FAIL b2b_next got fd=%b ack=%b exp 1/0", frame_done, load_ack); else passes++;
    endtask

    task automatic test_boundary_load;
        do_load(16'h5555, 4'h0, 4'hF);
        step(38);
        // load is asserted across the boundary edge
        data_in = 16'h6666; dp_in = 4'h0; en_in = 4'hF; load = 1'b1;
        step(1);
        load = 1'b0;
        checks++; if (load_ack !== 1'b1 || frame_done !== 1'b1) $display("FAIL bl_ack1 got ack=%b fd=%b exp 1/1", load_ack, frame_done); else passes++;
        checks++; if (SEG !== 7'h12) $display("FAIL bl_old got %h exp 12", SEG); else passes++;
        step(40);
        checks++; if (load_ack !== 1'b1) $display("FAIL bl_ack2 got %b exp 1", load_ack); else passes++;
        checks++; if (SEG !== 7'h02) $display("FAIL bl_new got %h exp 02", SEG); else passes++;
    endtask

    task automatic test_enable_mask;
        do_load(16'h4321, 4'h0, 4'b1011);
        step(39);
        checks++; if (load_ack !== 1'b1 || AN !== 4'b1110) $display("FAIL en_ack got ack=%b an=%b exp 1/1110", load_ack, AN); else passes++;
        step(20);
        checks++; if (AN !== 4'hF || SEG !== 7'h30) $display("FAIL en_d2 got an=%b seg=%h exp 1111/30", AN, SEG); else passes++;
        step(7);
        checks++; if (AN !== 4'hF) $display("FAIL en_d2_end got %b exp 1111", AN); else passes++;
        step(3);
        checks++; if (AN !== 4'b0111 || SEG !== 7'h19) $display("FAIL en_d3 got %b/%h exp 0111/19", AN, SEG); else passes++;
        step(9);
        checks++; if (frame_done !== 1'b0) $display("FAIL en_early_fd got %b exp 0", frame_done); else passes++;
        step(1);
        checks++; if (frame_done !== 1'b1) $display("FAIL en_period got %b exp 1", frame_done); else passes++;
    endtask

    task automatic test_reset_mid;
        do_load(16'h9999, 4'hF, 4'hF);
        step(19);
        checks++; if (AN !== 4'hF || SEG !== 7'h30) $display("FAIL rm_d2 got an=%b seg=%h exp 1111/30", AN, SEG); else passes++;
        step(2);
        RSTN = 1'b0;
        step(1);
        checks++; if (AN !== 4'hF || SEG !== 7'h7F || DP !== 1'b1 || load_ack !== 1'b0) $display("FAIL rm_off got %b/%h/%b/%b exp 1111/7f/1/0", AN, SEG, DP, load_ack); else passes++;
        RSTN = 1'b1;
        step(2);
        checks++; if (frame_done !== 1'b1 || load_ack !== 1'b0) $display("FAIL rm_b0 got fd=%b ack=%b exp 1/0", frame_done, load_ack); else passes++;
        checks++; if (SEG !== 7'h40 || AN !== 4'hF || DP !== 1'b1) $display("FAIL rm_d0 got %h/%b/%b exp 40/1111/1", SEG, AN, DP); else passes++;
        step(40);
        checks++; if (frame_done !== 1'b1 || load_ack !== 1'b0) $display("FAIL rm_noack got fd=%b ack=%b exp 1/0", frame_done, load_ack); else passes++;
    endtask

    task automatic test_free_run;
        int last_fd, fd_cnt, fd_bad, an_bad, blank_bad, blank_run, waited;
        logic [3:0] prev_an;
        do_load(16'hFEDC, 4'h0, 4'hF);
        waited = 0;
        while (frame_done !== 1'b1 && waited < 60) begin
            step(1);
            waited++;
        end
        checks++; if (frame_done !== 1'b1) $display("FAIL fr_sync got no frame_done in %0d cycles", waited); else passes++;
        last_fd = 0; fd_cnt = 0; fd_bad = 0; an_bad = 0; blank_bad = 0; blank_run = 0;
        prev_an = AN;
        for (int c = 1; c <= 400; c++) begin
            step(1);
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (c - last_fd != 40) fd_bad++;
                last_fd = c;
            end
            if ($countones(~AN) > 1) an_bad++;
            if (AN === 4'hF) blank_run++;
            else begin
                if (prev_an === 4'hF && blank_run != 2) blank_bad++;
                blank_run = 0;
            end
            prev_an = AN;
        end
        checks++; if (fd_cnt != 10) $display("FAIL fr_count got %0d exp 10", fd_cnt); else passes++;
        checks++; if (fd_bad != 0) $display("FAIL fr_period got %0d bad intervals exp 0", fd_bad); else passes++;
        checks++; if (an_bad != 0) $display("FAIL fr_onehot got %0d bad cycles exp 0", an_bad); else passes++;
        checks++; if (blank_bad != 0) $display("FAIL fr_blank got %0d short blanks exp 0", blank_bad); else passes++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_boundary_load;
        test_enable_mask;
        test_reset_mid;
        test_free_run;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Hard stop in case the scan stalls.
    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000ns");
        $fatal(1);
    end

endmodule
